// File: rtl/gray_step_tracker_if.sv
// Purpose     : bundles the Gray sample input, clear and all tracker results into one port.
// Latency     : none, wiring only.
// Backpressure: none; the tracker takes one Gray word per clock.
// Ports       : gray_in, clear (driver -> tracker); bin, pos, up, down, err, fault, err_cnt (tracker -> consumer).
// Modports    : master = upstream driver/consumer side, slave = gray_step_tracker side.
interface gray_step_tracker_if #(
  parameter int WIDTH = 3,
  parameter int POS_W = 8
);
  logic [WIDTH-1:0] gray_in;
  logic             clear;
  logic [WIDTH-1:0] bin;
  logic [POS_W-1:0] pos;
  logic             up;
  logic             down;
  logic             err;
  logic             fault;
  logic [7:0]       err_cnt;

  modport master (
    output gray_in, clear,
    input  bin, pos, up, down, err, fault, err_cnt
  );

  modport slave (
    input  gray_in, clear,
    output bin, pos, up, down, err, fault, err_cnt
  );
endinterface

// File: rtl/gray_step_tracker.sv
// Purpose     : decodes a Gray counter word, classifies each change as up/down/illegal, tracks position and errors.
// Latency     : gray_in change to bin/pos/pulse is 2 edges, or 3 edges when GRAY_TRACK_SYNC_EN is defined.
// Backpressure: none; one Gray step per clock is absorbed without loss.
// Ports       : clk, reset (sync, active-low); bus.gray_in, bus.clear in;
//               bus.bin, bus.pos, bus.up, bus.down, bus.err, bus.fault, bus.err_cnt out.
// Build macro : GRAY_TRACK_SYNC_EN adds a two-flop synchronizer in front of the decoder.
module gray_step_tracker #(
  parameter int WIDTH = 3,
  parameter int POS_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  gray_step_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DELTA_FWD = WIDTH'(1);
  localparam logic [WIDTH-1:0] DELTA_BWD = '1;

  // s is the sample the decoder looks at; s_vld marks that s holds a value
  // captured after reset release, so the INIT baseline is never the flushed zero.
  logic [WIDTH-1:0] s;
  logic             s_vld;

`ifdef GRAY_TRACK_SYNC_EN
  logic [WIDTH-1:0] s_meta;
  logic             meta_vld;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_meta   <= '0;
      s        <= '0;
      meta_vld <= 1'b0;
      s_vld    <= 1'b0;
    end else begin
      s_meta   <= bus.gray_in;
      s        <= s_meta;
      meta_vld <= 1'b1;
      s_vld    <= meta_vld;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      s     <= '0;
      s_vld <= 1'b0;
    end else begin
      s     <= bus.gray_in;
      s_vld <= 1'b1;
    end
  end
`endif

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  logic [WIDTH-1:0] dec;
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = ^(s >> i);
    end
  end

  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] delta;
  assign delta = dec - prev_bin;

  logic step_illegal;
  assign step_illegal = (delta != '0) && (delta != DELTA_FWD) && (delta != DELTA_BWD);

  state_t           state;
  logic [WIDTH-1:0] bin_q;
  logic [POS_W-1:0] pos_q;
  logic             up_q;
  logic             down_q;
  logic             err_q;
  logic             fault_q;
  logic [7:0]       err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_INIT;
      prev_bin  <= '0;
      bin_q     <= '0;
      pos_q     <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      err_q     <= 1'b0;
      fault_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.clear) begin
        // clear wins over any step seen this cycle; bin keeps following the input.
        state     <= ST_INIT;
        prev_bin  <= dec;
        bin_q     <= dec;
        pos_q     <= '0;
        fault_q   <= 1'b0;
        err_cnt_q <= '0;
      end else begin
        case (state)
          ST_INIT: begin
            if (s_vld) begin
              prev_bin <= dec;
              bin_q    <= dec;
              state    <= ST_TRACK;
            end
          end
          ST_TRACK: begin
            prev_bin <= dec;
            bin_q    <= dec;
            if (delta == DELTA_FWD) begin
              up_q  <= 1'b1;
              pos_q <= pos_q + POS_W'(1);
            end else if (delta == DELTA_BWD) begin
              down_q <= 1'b1;
              pos_q  <= pos_q - POS_W'(1);
            end else if (step_illegal) begin
              err_q   <= 1'b1;
              fault_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              state   <= ST_FAULT;
            end
          end
          ST_FAULT: begin
            // position is frozen; only illegal jumps are still reported.
            prev_bin <= dec;
            bin_q    <= dec;
            if (step_illegal) begin
              err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  assign bus.bin     = bin_q;
  assign bus.pos     = pos_q;
  assign bus.up      = up_q;
  assign bus.down    = down_q;
  assign bus.err     = err_q;
  assign bus.fault   = fault_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Purpose     : self-checking bench for gray_step_tracker against a sequence-table reference model.
// Latency     : follows the build; GRAY_TRACK_SYNC_EN selects 3 edges, otherwise 2.
// Backpressure: none; one input word per clock.
module tb_gray_step_tracker;

`ifdef GRAY_TRACK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam int M_INIT  = 0;
  localparam int M_TRACK = 1;
  localparam int M_FAULT = 2;

  // The 3-bit reflected Gray sequence: position i of the count holds GT[i].
  int GT [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gray_step_tracker_if #(.WIDTH(3), .POS_W(8)) bus ();

  gray_step_tracker #(.WIDTH(3), .POS_W(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int hist[$];
  int since;
  int m_mode;
  int m_bin, m_prev, m_pos, m_cnt;
  int m_up, m_down, m_err, m_fault;

  function automatic int g2b(input int g);
    for (int i = 0; i < 8; i++) if (GT[i] == g) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int g, input bit clr, input bit rst_n);
    int d, dl;
    bit valid;
    m_up = 0; m_down = 0; m_err = 0;
    if (!rst_n) begin
      m_mode = M_INIT; m_bin = 0; m_prev = 0; m_pos = 0; m_cnt = 0; m_fault = 0;
      since = 0;
      hist.delete();
    end else begin
      // the decision this edge sees the word applied LAT-1 edges ago, if captured after release
      valid = (since >= LAT - 1);
      d = valid ? g2b(hist[hist.size() - (LAT - 1)]) : 0;
      dl = (d - m_prev + 8) % 8;
      if (clr) begin
        m_mode = M_INIT; m_pos = 0; m_cnt = 0; m_fault = 0; m_bin = d; m_prev = d;
      end else if (m_mode == M_INIT) begin
        if (valid) begin m_bin = d; m_prev = d; m_mode = M_TRACK; end
      end else begin
        m_bin = d; m_prev = d;
        if (m_mode == M_TRACK && dl == 1) begin
          m_up = 1; m_pos = (m_pos + 1) % 256;
        end else if (m_mode == M_TRACK && dl == 7) begin
          m_down = 1; m_pos = (m_pos + 255) % 256;
        end else if (dl != 0 && dl != 1 && dl != 7) begin
          m_err = 1; m_fault = 1; m_mode = M_FAULT;
          if (m_cnt < 255) m_cnt++;
        end
      end
      hist.push_back(g);
      if (hist.size() > 8) void'(hist.pop_front());
      if (since < 1000) since++;
    end
  endtask

  task automatic cycle(input int g, input bit clr = 1'b0, input bit rst_n = 1'b1);
    bus.gray_in = 3'(g);
    bus.clear   = clr;
    rst         = rst_n;
    @(posedge clk);
    model_edge(g, clr, rst_n);
    #1;
    chk("bin",     32'(bus.bin),     32'(m_bin));
    chk("pos",     32'(bus.pos),     32'(m_pos));
    chk("up",      32'(bus.up),      32'(m_up));
    chk("down",    32'(bus.down),    32'(m_down));
    chk("err",     32'(bus.err),     32'(m_err));
    chk("fault",   32'(bus.fault),   32'(m_fault));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
  endtask

  initial begin
    int g;
    int r;
    bus.gray_in = '0;
    bus.clear   = 1'b0;
    rst         = 1'b0;
    since = 0; m_mode = M_INIT;
    m_bin = 0; m_prev = 0; m_pos = 0; m_cnt = 0;
    m_up = 0; m_down = 0; m_err = 0; m_fault = 0;

    // reset state
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("rst_pos", 32'(bus.pos), 32'd0);

    // full forward lap: eight up steps, pos 8
    repeat (3) cycle(0);
    for (int i = 1; i <= 8; i++) cycle(GT[i % 8]);
    repeat (3) cycle(0);
    chk("lap_pos", 32'(bus.pos), 32'd8);
    chk("lap_fault", 32'(bus.fault), 32'd0);

    // backward wrap: 0 -> 255 -> 254
    cycle(0, 1);
    repeat (3) cycle(0);
    cycle(4);
    cycle(5);
    repeat (3) cycle(5);
    chk("wrap_pos", 32'(bus.pos), 32'd254);
    chk("wrap_bin", 32'(bus.bin), 32'd6);

    // illegal jump, frozen position, clear
    cycle(0, 1);
    repeat (3) cycle(0);
    cycle(3);
    repeat (2) cycle(3);
    cycle(2);
    cycle(6);
    repeat (3) cycle(6);
    chk("jump_fault", 32'(bus.fault), 32'd1);
    chk("jump_cnt", 32'(bus.err_cnt), 32'd1);
    cycle(6, 1);
    repeat (3) cycle(6);
    chk("clr_fault", 32'(bus.fault), 32'd0);
    chk("clr_cnt", 32'(bus.err_cnt), 32'd0);
    chk("clr_bin", 32'(bus.bin), 32'd4);

    // reset mid-operation at pos 5, new baseline from post-release capture
    cycle(0, 1);
    repeat (3) cycle(0);
    for (int i = 1; i <= 5; i++) cycle(GT[i]);
    repeat (3) cycle(7);
    chk("pre_rst_pos", 32'(bus.pos), 32'd5);
    cycle(6, 0, 0);
    chk("mid_rst_pos", 32'(bus.pos), 32'd0);
    chk("mid_rst_bin", 32'(bus.bin), 32'd0);
    repeat (3) cycle(6);
    chk("rebase_bin", 32'(bus.bin), 32'd4);
    cycle(7);
    repeat (LAT - 2) cycle(7);
    chk("lat_early_up", 32'(bus.up), 32'd0);
    cycle(7);
    chk("lat_up", 32'(bus.up), 32'd1);
    chk("lat_pos", 32'(bus.pos), 32'd1);

    // error counter saturation
    cycle(0, 1);
    repeat (3) cycle(0);
    for (int i = 0; i < 300; i++) cycle((i % 2 == 0) ? 3 : 0);
    repeat (3) cycle(0);
    chk("sat_cnt", 32'(bus.err_cnt), 32'd255);
    chk("sat_fault", 32'(bus.fault), 32'd1);

    // clear in the same cycle the forward step is decided
    cycle(0, 1);
    repeat (3) cycle(0);
    cycle(1);
    repeat (LAT - 2) cycle(1);
    cycle(1, 1);
    chk("clr_step_up", 32'(bus.up), 32'd0);
    chk("clr_step_pos", 32'(bus.pos), 32'd0);
    repeat (3) cycle(1);
    chk("clr_step_base", 32'(bus.pos), 32'd0);

    // randomized walk: mostly legal steps, some jumps, clears and resets
    g = 1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      g = GT[(g2b(g) + 1) % 8];
      else if (r < 70) g = GT[(g2b(g) + 7) % 8];
      else if (r < 90) g = g;
      else             g = $urandom_range(0, 7);
      cycle(g, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_step_tracker.md
# gray_step_tracker

Downstream consumer of the 3-bit Gray-code counter stage. Samples the Gray word, decodes it to binary, classifies every change as a forward step, a backward step or an illegal jump, and keeps a signed-wrap position count plus an error counter. Sits between the Gray counter output `y` and any logic that needs a position or step events.

## Interface
- `WIDTH`, 3: Gray word width.
- `POS_W`, 8: position counter width.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `gray_in` input WIDTH: Gray word from upstream counter.
- `clear` input 1: synchronous clear of position, errors and tracking state.
- `bin` output WIDTH: registered binary decode of last accepted sample.
- `pos` output POS_W: position count, modulo 2^POS_W.
- `up` output 1: one-cycle pulse on forward step.
- `down` output 1: one-cycle pulse on backward step.
- `err` output 1: one-cycle pulse on illegal jump.
- `fault` output 1: sticky, set by illegal jump.
- `err_cnt` output 8: illegal-jump count, saturating at 255.

## Operation
- Sample path: `gray_in` registered into `s` (see Configuration); `dec` = combinational Gray-to-binary of `s` (bit i = XOR of `s` bits WIDTH-1 down to i).
- `delta` = (`dec` − `prev_bin`) mod 2^WIDTH.
- States: INIT, TRACK, FAULT.
- INIT: at next edge `prev_bin`<=`dec`, `bin`<=`dec`, no pulses, go TRACK.
- TRACK, each edge: `prev_bin`<=`dec`, `bin`<=`dec`; then
  - `delta`==0: no pulse, `pos` unchanged.
  - `delta`==1: `up`=1, `pos`+1 (wraps 2^POS_W−1 -> 0).
  - `delta`==2^WIDTH−1: `down`=1, `pos`−1 (wraps 0 -> 2^POS_W−1).
  - any other: `err`=1, `fault`=1, `err_cnt`+1 unless 255, go FAULT.
- FAULT: `bin`, `prev_bin` keep following `dec`; `pos` frozen; no `up`/`down`; further illegal jumps still pulse `err` and increment `err_cnt`. Exit only via `clear` or reset.
- `clear`=1 (with reset inactive): `pos`=0, `err_cnt`=0, `fault`=0, pulses 0, state INIT; `bin` keeps updating to `dec`. `clear` overrides any step or jump in the same cycle.
- Reset (`reset`=0) overrides `clear` and everything else.
- Reset values: `bin`=0, `pos`=0, `up`=`down`=`err`=0, `fault`=0, `err_cnt`=0, `prev_bin`=0, sample registers 0, state INIT.

## Timing
- Pulses `up`/`down`/`err` last exactly one cycle; at most one asserted per cycle.
- Latency, `gray_in` change to `bin`/`pos`/pulse update: 3 rising edges with synchronizer, 2 without.
- Sustained input rate: one Gray step per clock, no loss.
- First edge after reset release or `clear` is INIT: the value then in `s` becomes baseline with no pulse, regardless of its value.
- Reset asserted mid-operation: outputs at reset values after the sampling edge; sample registers also cleared, so the first post-reset baseline is the value captured after release.

## Configuration
- `GRAY_TRACK_SYNC_EN` defined: `gray_in` passes a two-flop synchronizer (`s` = second flop); latency 3 edges; for asynchronous upstream sources.
- Not defined: single input register (`s` = that register); latency 2 edges; for same-clock upstream. All other behaviour identical.

## Test plan
- Reset, then feed 000,001,011,010,110,111,101,100,000 one per cycle -> `bin` 0..7,0; eight `up` pulses; `pos`=8; `err`, `fault`, `down` never asserted.
- From baseline 000 feed 100 then 101 -> two `down` pulses; `pos` 0->255->254 (wrap).
- Baseline 000 then 011 (delta 2) -> `err` one cycle, `fault`=1, `err_cnt`=1; following legal steps leave `pos` frozen; `clear` -> `pos`=0, `fault`=0, `err_cnt`=0, next sample baseline without pulse.
- Reach `pos`=5, assert `reset`=0 one cycle -> all outputs reset values; release, feed 110 -> no pulse, `bin`=4; next 111 -> `up`, `pos`=1.
- 300 illegal jumps (alternate 000/011) -> `err_cnt` saturates at 255; `clear` in same cycle as a forward step -> no `up`, `pos`=0.
- Build with and without `GRAY_TRACK_SYNC_EN`: single step 000->001 -> `up` exactly 3 and 2 edges after the change respectively.
